// File: rtl/dut_out_sampler.sv
// Capture stage for DUT passthrough outputs: packs each enabled sample into one word and buffers it in a FWFT FIFO.
// Optional running checksum of accepted samples is enabled by defining DUT_OUT_SAMPLER_CHECKSUM_EN.
module dut_out_sampler #(
    parameter int DATA_WIDTH = 4,
    parameter int BUS_WIDTH  = 2,
    parameter int DEPTH      = 4,
    localparam int W  = 1 + BUS_WIDTH + DATA_WIDTH * (BUS_WIDTH + 1),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                         clk1,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         sample_en,
    input  logic                         s_out1,
    input  logic                         s_out2 [BUS_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] s_out3,
    input  logic signed [DATA_WIDTH-1:0] s_out4 [BUS_WIDTH],
    output logic [W-1:0]                 m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [CW-1:0]                count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic [15:0]                  drop_cnt,
    output logic signed [31:0]           checksum
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic [15:0]   drop_cnt_reg;
    logic [W-1:0]  sample_word;
    logic          push;
    logic          pop;
    logic          drop;

    // Field order MSB..LSB: out1, out2[BW-1..0], out3, out4[BW-1..0]; bits copied as-is.
    genvar gi;
    generate
        for (gi = 0; gi < BUS_WIDTH; gi++) begin : g_pack
            assign sample_word[gi*DATA_WIDTH +: DATA_WIDTH]          = s_out4[gi];
            assign sample_word[(BUS_WIDTH+1)*DATA_WIDTH + gi]        = s_out2[gi];
        end
    endgenerate
    assign sample_word[BUS_WIDTH*DATA_WIDTH +: DATA_WIDTH] = s_out3;
    assign sample_word[W-1]                                = s_out1;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign m_valid  = !empty;
    assign m_data   = mem_reg[rd_ptr_reg];
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;

    // clear suppresses any transfer requested in the same cycle.
    assign pop  = m_valid && m_ready && !clear;
    assign push = sample_en && (!full || pop) && !clear;
    assign drop = sample_en && full && !pop && !clear;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= sample_word;
                wr_ptr_reg          <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (clear) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != 16'hFFFF) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

`ifdef DUT_OUT_SAMPLER_CHECKSUM_EN
    logic signed [31:0] sample_sum;
    logic signed [31:0] checksum_reg;

    always_comb begin
        sample_sum = {{(32-DATA_WIDTH){s_out3[DATA_WIDTH-1]}}, s_out3};
        for (int i = 0; i < BUS_WIDTH; i++) begin
            sample_sum = sample_sum + {{(32-DATA_WIDTH){s_out4[i][DATA_WIDTH-1]}}, s_out4[i]};
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            checksum_reg <= '0;
        end else if (clear) begin
            checksum_reg <= '0;
        end else if (push) begin
            checksum_reg <= checksum_reg + sample_sum;
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_dut_out_sampler.sv
// Self-checking bench for dut_out_sampler: directed scenarios plus a randomized phase against a queue-based model.
module tb_dut_out_sampler;

    localparam int DW    = 4;
    localparam int BW    = 2;
    localparam int DEPTH = 4;
    localparam int W     = 1 + BW + DW * (BW + 1);
    localparam int CW    = $clog2(DEPTH + 1);

    logic                 clk1 = 1'b0;
    logic                 rst_n;
    logic                 clear;
    logic                 sample_en;
    logic                 s_out1;
    logic                 s_out2 [BW];
    logic signed [DW-1:0] s_out3;
    logic signed [DW-1:0] s_out4 [BW];
    logic [W-1:0]         m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 overflow;
    logic [15:0]          drop_cnt;
    logic signed [31:0]   checksum;

    dut_out_sampler #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk1(clk1), .rst_n(rst_n), .clear(clear), .sample_en(sample_en),
        .s_out1(s_out1), .s_out2(s_out2), .s_out3(s_out3), .s_out4(s_out4),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .drop_cnt(drop_cnt), .checksum(checksum)
    );

    always #5 clk1 = ~clk1;

    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  q [$];
    bit            m_ovf;
    int            m_drop;
    int            m_csum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_model();
        logic [W-1:0] w;
        w = W'(s_out1);
        for (int i = BW - 1; i >= 0; i--) w = (w << 1) | W'(s_out2[i]);
        w = (w << DW) | W'($unsigned(s_out3));
        for (int i = BW - 1; i >= 0; i--) w = (w << DW) | W'($unsigned(s_out4[i]));
        return w;
    endfunction

    function automatic int sum_model();
        int s;
        s = int'(s_out3);
        for (int i = 0; i < BW; i++) s = s + int'(s_out4[i]);
        return s;
    endfunction

    function automatic int exp_csum();
`ifdef DUT_OUT_SAMPLER_CHECKSUM_EN
        return m_csum;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        m_csum = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".m_valid"},  32'(m_valid),  32'(q.size() > 0));
        chk({tag, ".count"},    32'(count),    32'(q.size()));
        chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
        chk({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        chk({tag, ".checksum"}, checksum,      32'(exp_csum()));
        if (q.size() > 0) chk({tag, ".m_data"}, 32'(m_data), 32'(q[0]));
    endtask

    // Called at a negedge with s_* already set; applies controls across one posedge.
    task automatic step(input string tag, input bit se, input bit rdy, input bit clr);
        logic [W-1:0] word;
        int           s;
        bit           p;
        bit           pu;
        sample_en = se;
        m_ready   = rdy;
        clear     = clr;
        word      = pack_model();
        s         = sum_model();
        if (clr) begin
            model_reset();
        end else begin
            p  = (q.size() > 0) && rdy;
            pu = se && ((q.size() < DEPTH) || p);
            if (p) void'(q.pop_front());
            if (pu) begin
                q.push_back(word);
                m_csum = m_csum + s;
            end else if (se) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop++;
            end
        end
        @(posedge clk1);
        #1;
        check_all(tag);
        $display("step %-10s se=%0b rdy=%0b clr=%0b word=%h count=%0d m_data=%h drop=%0d", tag, se, rdy, clr,
                 word, count, m_data, drop_cnt);
        @(negedge clk1);
    endtask

    task automatic set_fields(input bit o1, input bit o2_1, input bit o2_0,
                              input int o3, input int o4_1, input int o4_0);
        s_out1    = o1;
        s_out2[1] = o2_1;
        s_out2[0] = o2_0;
        s_out3    = DW'(o3);
        s_out4[1] = DW'(o4_1);
        s_out4[0] = DW'(o4_0);
    endtask

    task automatic randomize_fields();
        s_out1 = 1'($urandom_range(0, 1));
        for (int i = 0; i < BW; i++) begin
            s_out2[i] = 1'($urandom_range(0, 1));
            s_out4[i] = DW'($urandom_range(0, (1 << DW) - 1));
        end
        s_out3 = DW'($urandom_range(0, (1 << DW) - 1));
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        sample_en = 1'b0;
        m_ready   = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0);
        model_reset();

        // Reset held for three cycles, released away from the clock edge.
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;
        #1;
        check_all("reset");
        chk("reset.m_data", 32'(m_data), 32'h0);
        @(negedge clk1);

        // Single sample lands at the head immediately after its edge.
        set_fields(1, 1, 0, -3, 7, -8);
        step("single", 1, 0, 0);
        chk("single.const", 32'(m_data), 32'h6D78);
        step("pop1", 0, 1, 0);

        // Fill past capacity: two samples dropped.
        for (int i = 1; i <= 6; i++) begin
            randomize_fields();
            s_out3 = DW'(i);
            step($sformatf("fill%0d", i), 1, 0, 0);
        end
        chk("fill.drop_cnt", 32'(drop_cnt), 32'd2);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_field%0d", i), 32'(m_data[BW*DW +: DW]), 32'(i));
            step($sformatf("drain%0d", i), 0, 1, 0);
        end
        chk("drain.empty", 32'(empty), 32'd1);

        // Full FIFO with simultaneous push and pop: no drops, continuous order.
        for (int i = 0; i < DEPTH; i++) begin
            randomize_fields();
            step($sformatf("refill%0d", i), 1, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            randomize_fields();
            step($sformatf("fullpp%0d", i), 1, 1, 0);
        end
        chk("fullpp.count", 32'(count), 32'(DEPTH));

        // Down to two entries with overflow set, then clear with a concurrent sample.
        step("trim0", 0, 1, 0);
        step("trim1", 0, 1, 0);
        chk("trim.overflow", 32'(overflow), 32'd1);
        randomize_fields();
        step("clear", 1, 1, 1);
        chk("clear.count", 32'(count), 32'd0);

        // Checksum: one zero sample, three scenario samples, one dropped.
        set_fields(0, 0, 0, 0, 0, 0);
        step("cs_zero", 1, 0, 0);
        set_fields(1, 1, 0, -3, 7, -8);
        for (int i = 0; i < 3; i++) step($sformatf("cs_acc%0d", i), 1, 0, 0);
        step("cs_drop", 1, 0, 0);
`ifdef DUT_OUT_SAMPLER_CHECKSUM_EN
        chk("cs.const", checksum, 32'hFFFF_FFF4);
`else
        chk("cs.const", checksum, 32'h0);
`endif
        step("cs_clear", 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            randomize_fields();
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-operation takes effect before any clock edge.
        for (int i = 0; i < 3; i++) begin
            randomize_fields();
            step($sformatf("pre_rst%0d", i), 1, 0, 0);
        end
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        @(negedge clk1);
        rst_n = 1'b1;
        randomize_fields();
        step("post_rst", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dut_out_sampler.md
Name: dut_out_sampler

Overview:
- Downstream capture stage for the DUT smoke-test path.
- Samples the DUT passthrough outputs (single bit, bit bus, signed word, signed word bus) on `clk1` when enabled.
- Packs each sample into one word and buffers it in a first-word-fall-through FIFO.
- The bench drains the FIFO through a valid/ready interface; overflow and drop statistics are recorded for the scoreboard.

Parameters:
- DATA_WIDTH, 4: width of each signed data word.
- BUS_WIDTH, 2: number of elements in each unpacked bus.
- DEPTH, 4: FIFO entries; must be a power of two and at least 2.

Ports:
- clk1  input  1  sampling clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush of FIFO and statistics.
- sample_en  input  1  capture the s_* inputs this cycle.
- s_out1  input  1  DUT out1.
- s_out2  input  1 x [BUS_WIDTH] (unpacked)  DUT out2.
- s_out3  input  signed DATA_WIDTH  DUT out3.
- s_out4  input  signed DATA_WIDTH x [BUS_WIDTH] (unpacked)  DUT out4.
- m_data  output  W = 1+BUS_WIDTH+DATA_WIDTH*(BUS_WIDTH+1)  head-of-FIFO packed sample.
- m_valid  output  1  m_data holds a valid entry.
- m_ready  input  1  consumer accepts m_data.
- count  output  $clog2(DEPTH+1)  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag: a sample was dropped.
- drop_cnt  output  16  number of dropped samples, saturating.
- checksum  output  signed 32  running sum (optional feature).

Behaviour:
- Clocking and reset:
  - Single clock `clk1`.
  - The reset is asynchronous and active-low (`rst_n`).
  - On reset: all outputs go to 0, except `empty`, which goes to 1. Pointers go to 0.
  - Reset asserted mid-operation discards all buffered data immediately, without waiting for a clock edge.
- Packing, MSB to LSB:
  - s_out1
  - s_out2[BUS_WIDTH-1] down to s_out2[0]
  - s_out3
  - s_out4[BUS_WIDTH-1] down to s_out4[0]
  - Each field is copied bit-exact; no sign extension is applied.
- Push and pop conditions:
  - push = sample_en && (!full || pop).
  - pop = m_valid && m_ready.
- Latency and FIFO behaviour:
  - A sample captured at edge k appears on m_data/m_valid immediately after edge k if the FIFO was empty.
  - Otherwise it appears in FIFO order.
  - m_valid = !empty. m_data is combinational from the memory at the read pointer.
  - While m_valid = 0, m_data holds its last value and is don't-care.
  - Pointers wrap modulo DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Full with pop in the same cycle: push is accepted, count stays DEPTH, no drop.
- Full without pop, sample_en = 1:
  - The sample is dropped.
  - overflow is set and stays set until clear or reset.
  - drop_cnt increments, saturating at 16'hFFFF.
- Empty with m_ready = 1: no pop, no state change.
- Empty with push and m_ready in the same cycle: no bypass; the entry is popped on a later cycle.
- clear:
  - Highest priority after reset.
  - Next cycle: count = 0, empty = 1, overflow = 0, drop_cnt = 0, checksum = 0.
  - A push or pop requested in the same cycle as clear is ignored.

Optional Feature:
- Macro: DUT_OUT_SAMPLER_CHECKSUM_EN.
- When defined:
  - On every accepted push, checksum += sign-extended s_out3 + sum of all sign-extended s_out4[i].
  - Arithmetic is modulo 2^32.
  - Dropped samples are not counted.
  - checksum is cleared by rst_n or clear.
- When not defined: the checksum port still exists, is tied to 32'h0, and no accumulator logic is synthesised.

Test Plan:
1. Assert rst_n = 0 for 3 cycles, then release -> count = 0, empty = 1, full = 0, m_valid = 0, overflow = 0, drop_cnt = 0, checksum = 0.
2. One cycle with sample_en = 1, m_ready = 0, s_out1 = 1, s_out2[1] = 1, s_out2[0] = 0, s_out3 = -3, s_out4[1] = 7, s_out4[0] = -8 -> after the edge: m_valid = 1, m_data = 15'h6D78, count = 1.
3. DEPTH = 4, m_ready = 0, 6 consecutive samples with s_out3 = 1..6 -> full = 1, count = 4, overflow = 1, drop_cnt = 2. Then drain with m_ready = 1 -> s_out3 fields read back 1, 2, 3, 4 in order, then empty = 1.
4. FIFO full, sample_en = 1 and m_ready = 1 for 3 cycles -> count stays 4, drop_cnt unchanged, output order continuous with no gaps.
5. 2 entries buffered, overflow = 1, clear = 1 together with sample_en = 1 -> next cycle count = 0, empty = 1, overflow = 0, drop_cnt = 0, and the concurrent sample is not stored.
6. With DUT_OUT_SAMPLER_CHECKSUM_EN defined, 3 accepted samples of the scenario 2 values, then 1 dropped sample (per-sample sum -4) -> checksum = 32'hFFFFFFF4. Without the macro -> checksum = 0.
